// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-wide memory access, little-endian lane alignment,
// load extension and read-modify-write sub-word stores. Optional: LSU_ALIGN_CHECK_EN.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wd,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rd,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    output logic        o_mem_wen,
    output logic        o_mem_ren,
    input  logic [31:0] i_mem_rd
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rd_q, rd_d;

    logic        req_err;
    logic        req_sw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    // Rejection is decided once, from the raw request, at the accept edge.
    always_comb begin
        req_err = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                  ((i_funct3[2:1] == 2'b10) && i_we) || (i_addr >= MEM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
        if ((i_funct3[1:0] == 2'b01 && i_addr[0]) ||
            (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
        req_sw = i_we && (i_funct3 == 3'b010);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wd_q     <= '0;
            merge_q  <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            err_q    <= err_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            merge_q  <= merge_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    if (req_err)     state_d = S_DONE;
                    else if (req_sw) state_d = S_WRITE;
                    else             state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = we_q ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane selection: byte k at [8k+7:8k], halfword j at [16j+15:16j].
    always_comb begin
        ld_byte = i_mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half = i_mem_rd[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q[1:0])
            2'b00:   ld_ext = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: ld_ext = i_mem_rd;
        endcase
        merged = i_mem_rd;
        if (funct3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
    end

    always_comb begin
        we_d     = we_q;
        err_d    = err_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        merge_d  = merge_q;
        rd_d     = rd_q;
        if (state_q == S_IDLE && i_req) begin
            we_d     = i_we;
            err_d    = req_err;
            funct3_d = i_funct3;
            addr_d   = i_addr;
            wd_d     = i_wd;
        end else if (state_q == S_WAIT) begin
            if (we_q) merge_d = merged;
            else      rd_d    = ld_ext;
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        o_busy     = (state_q != S_IDLE);
        o_done     = (state_q == S_DONE);
        o_err      = (state_q == S_DONE) && err_q;
        o_mem_ren  = (state_q == S_READ);
        o_mem_wen  = (state_q == S_WRITE);
        o_mem_addr = {addr_q[31:2], 2'b00};
        o_mem_wd   = (funct3_q[1:0] == 2'b10) ? wd_q : merge_q;
        o_rd       = rd_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// checked against a byte-array reference model.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wd = '0;
    logic        o_busy, o_done, o_err, o_mem_wen, o_mem_ren;
    logic [31:0] o_rd, o_mem_addr, o_mem_wd;
    logic [31:0] mem_rd;
    logic        mem_init = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [31:0] last_rd = '0;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wd(i_wd),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rd(o_rd),
        .o_mem_addr(o_mem_addr), .o_mem_wd(o_mem_wd),
        .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .i_mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Word-wide data memory: registered read, write sampled on the edge.
    logic [31:0] mem [0:MEM_BYTES/4-1];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] <= init_word(i);
        end else begin
            if (o_mem_wen) mem[o_mem_addr[7:2]] <= o_mem_wd;
            if (o_mem_ren) mem_rd <= mem[o_mem_addr[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic e;
        e = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
            (we && (f3 == 3'b100 || f3 == 3'b101)) || (addr >= MEM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && addr % 2 != 0) e = 1'b1;
        if (f3 == 3'b010 && addr % 4 != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        int b;
        int h;
        a = int'(addr[7:0]);
        b = int'(ref_mem[a]);
        h = int'(ref_mem[a - a % 2]) + 256 * int'(ref_mem[a - a % 2 + 1]);
        case (f3)
            3'b000:  return 32'(b >= 128 ? b - 256 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
            3'b101:  return 32'(h);
            default: return ref_word(a - a % 4);
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int a;
        a = int'(addr[7:0]);
        if (f3 == 3'b000) begin
            ref_mem[a] = wd[7:0];
        end else if (f3 == 3'b001) begin
            ref_mem[a - a % 2]     = wd[7:0];
            ref_mem[a - a % 2 + 1] = wd[15:8];
        end else begin
            for (int k = 0; k < 4; k++) ref_mem[a - a % 4 + k] = 8'(wd >> (8 * k));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) check("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    // One complete access with cycle-accurate strobe/done checks.
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        err_e;
        int          exp_done, exp_ren, exp_wen;
        int          done_c, ren_c, wen_c, ren_n, wen_n;
        logic        err_seen;
        logic [31:0] exp_wd, wd_seen, addr_seen, exp_rd;
        err_e = ref_err(we, f3, addr);
        exp_wd = '0;
        if (err_e)                   begin exp_done = 1; exp_ren = 0; exp_wen = 0; end
        else if (!we)                begin exp_done = 3; exp_ren = 1; exp_wen = 0; end
        else if (f3 == 3'b010)       begin exp_done = 2; exp_ren = 0; exp_wen = 1; end
        else                         begin exp_done = 4; exp_ren = 1; exp_wen = 3; end
        if (!err_e && !we) last_rd = ref_load(f3, addr);
        if (!err_e && we) begin
            ref_store(f3, addr, wd);
            exp_wd = ref_word(int'(addr[7:0]) & ~3);
        end
        exp_rd = last_rd;

        wait_idle();
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wd = wd;
        @(posedge clk);
        #1 i_req = 1'b0;
        done_c = 0; ren_c = 0; wen_c = 0; ren_n = 0; wen_n = 0;
        err_seen = 1'b0; wd_seen = '0; addr_seen = addr & ~32'd3;
        for (int c = 1; c <= 8 && done_c == 0; c++) begin
            @(negedge clk);
            if (o_mem_ren) begin ren_c = c; ren_n++; addr_seen = o_mem_addr; end
            if (o_mem_wen) begin wen_c = c; wen_n++; wd_seen = o_mem_wd; addr_seen = o_mem_addr; end
            if (o_done) begin done_c = c; err_seen = o_err; end
        end
        check({tag, ".done_cycle"}, 32'(done_c), 32'(exp_done));
        check({tag, ".err"}, 32'(err_seen), 32'(err_e));
        check({tag, ".ren_cycle"}, 32'(ren_c), 32'(exp_ren));
        check({tag, ".wen_cycle"}, 32'(wen_c), 32'(exp_wen));
        check({tag, ".strobes"}, 32'(ren_n + wen_n), 32'((exp_ren != 0) + (exp_wen != 0)));
        if (!err_e) check({tag, ".mem_addr"}, addr_seen, addr & ~32'd3);
        if (exp_wen != 0) check({tag, ".mem_wd"}, wd_seen, exp_wd);
        check({tag, ".rd"}, o_rd, exp_rd);
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs", {o_busy, o_done, o_err, o_mem_wen, o_mem_ren},  32'd0);
        check("reset.rd", o_rd, 32'd0);
        check("reset.mem_addr", o_mem_addr, 32'd0);
        check("reset.mem_wd", o_mem_wd, 32'd0);
        i_rst = 1'b0; mem_init = 1'b0;

        run_op("sw04", 1'b1, 3'b010, 32'h04, 32'hDEADBEEF);
        run_op("sw08", 1'b1, 3'b010, 32'h08, 32'h11223344);
        run_op("lw04", 1'b0, 3'b010, 32'h04, 32'h0);
        check("lw04.value", o_rd, 32'hDEADBEEF);
        run_op("lb07", 1'b0, 3'b000, 32'h07, 32'h0);
        check("lb07.value", o_rd, 32'hFFFFFFDE);
        run_op("lbu07", 1'b0, 3'b100, 32'h07, 32'h0);
        check("lbu07.value", o_rd, 32'h000000DE);
        run_op("lh04", 1'b0, 3'b001, 32'h04, 32'h0);
        check("lh04.value", o_rd, 32'hFFFFBEEF);
        run_op("lhu06", 1'b0, 3'b101, 32'h06, 32'h0);
        check("lhu06.value", o_rd, 32'h0000DEAD);
        run_op("sb09", 1'b1, 3'b000, 32'h09, 32'h000000AB);
        run_op("lw08", 1'b0, 3'b010, 32'h08, 32'h0);
        check("lw08.value", o_rd, 32'h1122AB44);
        run_op("sh03", 1'b1, 3'b001, 32'h03, 32'h0000BEEF);
        run_op("lw00", 1'b0, 3'b010, 32'h00, 32'h0);
        run_op("sw100", 1'b1, 3'b010, 32'h100, 32'h12345678);
        run_op("sbu_illegal", 1'b1, 3'b100, 32'h10, 32'h0);
        run_op("f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
        run_op("lb_ff", 1'b0, 3'b000, 32'hFF, 32'h0);

        // Reset while an SB sits in WAIT: no write, no done.
        run_op("sw08b", 1'b1, 3'b010, 32'h08, 32'h11223344);
        wait_idle();
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h09; i_wd = 32'hAB;
        @(posedge clk);
        #1 i_req = 1'b0;
        @(negedge clk);
        check("rst_mid.read", 32'(o_mem_ren), 32'd1);
        @(negedge clk);
        check("rst_mid.wait", {o_mem_ren, o_mem_wen, o_done}, 32'd0);
        i_rst = 1'b1;
        @(negedge clk);
        check("rst_mid.outputs", {o_busy, o_done, o_err, o_mem_wen, o_mem_ren}, 32'd0);
        check("rst_mid.data", o_rd | o_mem_addr | o_mem_wd, 32'd0);
        i_rst = 1'b0;
        last_rd = '0;
        run_op("lw08_after_rst", 1'b0, 3'b010, 32'h08, 32'h0);
        check("lw08_after_rst.value", o_rd, 32'h11223344);

        // Request held through a busy LW, then switched to SW 0x0C.
        wait_idle();
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h04; i_wd = 32'h0;
        @(posedge clk);
        begin
            int dc;
            dc = 0;
            for (int c = 1; c <= 8 && dc == 0; c++) begin
                @(negedge clk);
                if (o_done) dc = c;
            end
            check("b2b.lw_done_cycle", 32'(dc), 32'd3);
        end
        check("b2b.lw_value", o_rd, 32'hDEADBEEF);
        i_we = 1'b1; i_addr = 32'h0C; i_wd = 32'hCAFEF00D;
        @(negedge clk);
        check("b2b.idle_gap", {o_busy, o_mem_ren, o_mem_wen}, 32'd0);
        @(negedge clk);
        check("b2b.sw_wen", {o_busy, o_mem_wen, o_mem_ren}, 32'b110);
        check("b2b.sw_addr", o_mem_addr, 32'h0C);
        check("b2b.sw_wd", o_mem_wd, 32'hCAFEF00D);
        i_req = 1'b0;
        @(negedge clk);
        check("b2b.sw_done", {o_done, o_err}, 32'b10);
        ref_store(3'b010, 32'h0C, 32'hCAFEF00D);
        last_rd = 32'hDEADBEEF;
        run_op("lw0c", 1'b0, 3'b010, 32'h0C, 32'h0);
        check("lw0c.value", o_rd, 32'hCAFEF00D);

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? 32'(256 + $urandom_range(0, 300))
                                               : 32'($urandom_range(0, 255));
            run_op("rand", we, f3, addr, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
